// File: rtl/maze_solver.sv
// Right-hand wall-follower over a snapshot of a 16x16 maze bitmap, one move per clock.
// Optional build macro MAZE_SOLVER_PRUNE_EN: revisiting a marked cell erases the cell just left.
module maze_solver #(
  parameter  int MAZE_DIM  = 16,
  parameter  int STEP_W    = 10,
  parameter  int MAX_STEPS = 1023,
  localparam int CELLS     = MAZE_DIM * MAZE_DIM,
  localparam int CW        = $clog2(MAZE_DIM),
  localparam int IW        = $clog2(CELLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [CELLS-1:0]  maze_data_i,
  input  logic [CW-1:0]     start_x_i,
  input  logic [CW-1:0]     start_y_i,
  input  logic [CW-1:0]     goal_x_i,
  input  logic [CW-1:0]     goal_y_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              found_o,
  output logic [CW-1:0]     pos_x_o,
  output logic [CW-1:0]     pos_y_o,
  output logic [STEP_W-1:0] step_count_o,
  output logic [CELLS-1:0]  path_data_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {UP, RIGHT, DOWN, LEFT} heading_t;

  state_t              state_q;
  heading_t            heading_q;
  logic [CELLS-1:0]    map_q;
  logic [CELLS-1:0]    path_q;
  logic [CW-1:0]       pos_x_q, pos_y_q;
  logic [CW-1:0]       goal_x_q, goal_y_q;
  logic [STEP_W-1:0]   step_q;
  logic                busy_q, done_q, found_q;

  function automatic logic [IW-1:0] cell_idx(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return IW'(x) + IW'(MAZE_DIM) * IW'(y);
  endfunction

  logic [3:0]    nb_open;
  logic [CW-1:0] nb_x [4];
  logic [CW-1:0] nb_y [4];

  // Off-grid neighbours read as walls; coordinates never wrap.
  always_comb begin
    for (int d = 0; d < 4; d++) begin
      nb_x[d] = pos_x_q;
      nb_y[d] = pos_y_q;
    end
    nb_y[UP]    = pos_y_q - CW'(1);
    nb_x[RIGHT] = pos_x_q + CW'(1);
    nb_y[DOWN]  = pos_y_q + CW'(1);
    nb_x[LEFT]  = pos_x_q - CW'(1);
    nb_open[UP]    = (pos_y_q != '0) && map_q[cell_idx(nb_x[UP], nb_y[UP])];
    nb_open[RIGHT] = (pos_x_q != CW'(MAZE_DIM - 1)) && map_q[cell_idx(nb_x[RIGHT], nb_y[RIGHT])];
    nb_open[DOWN]  = (pos_y_q != CW'(MAZE_DIM - 1)) && map_q[cell_idx(nb_x[DOWN], nb_y[DOWN])];
    nb_open[LEFT]  = (pos_x_q != '0) && map_q[cell_idx(nb_x[LEFT], nb_y[LEFT])];
  end

  heading_t          hd_r, hd_b, hd_l, mv_dir;
  logic              stuck;
  logic [CW-1:0]     mv_x, mv_y;
  logic [IW-1:0]     mv_idx, start_idx;
  logic              mv_goal;
  logic [STEP_W-1:0] step_d;

  always_comb begin
    hd_r   = heading_t'(heading_q + 2'd1);
    hd_b   = heading_t'(heading_q + 2'd2);
    hd_l   = heading_t'(heading_q + 2'd3);
    mv_dir = heading_q;
    stuck  = 1'b0;
    if (nb_open[hd_r])           mv_dir = hd_r;
    else if (nb_open[heading_q]) mv_dir = heading_q;
    else if (nb_open[hd_l])      mv_dir = hd_l;
    else if (nb_open[hd_b])      mv_dir = hd_b;
    else                         stuck  = 1'b1;
    mv_x      = nb_x[mv_dir];
    mv_y      = nb_y[mv_dir];
    mv_idx    = cell_idx(mv_x, mv_y);
    start_idx = cell_idx(start_x_i, start_y_i);
    mv_goal   = (mv_x == goal_x_q) && (mv_y == goal_y_q);
    step_d    = step_q + STEP_W'(1);
  end

`ifdef MAZE_SOLVER_PRUNE_EN
  logic [IW-1:0] cur_idx;
  assign cur_idx = cell_idx(pos_x_q, pos_y_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      heading_q <= UP;
      map_q     <= '0;
      path_q    <= '0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      goal_x_q  <= '0;
      goal_y_q  <= '0;
      step_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            map_q     <= maze_data_i;
            pos_x_q   <= start_x_i;
            pos_y_q   <= start_y_i;
            goal_x_q  <= goal_x_i;
            goal_y_q  <= goal_y_i;
            heading_q <= UP;
            step_q    <= '0;
            found_q   <= 1'b0;
            path_q    <= '0;
            if (!maze_data_i[start_idx]) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              path_q[start_idx] <= 1'b1;
              if (start_x_i == goal_x_i && start_y_i == goal_y_i) begin
                found_q <= 1'b1;
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_RUN;
                busy_q  <= 1'b1;
              end
            end
          end
        end
        S_RUN: begin
          if (stuck) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            pos_x_q        <= mv_x;
            pos_y_q        <= mv_y;
            heading_q      <= mv_dir;
            step_q         <= step_d;
            path_q[mv_idx] <= 1'b1;
`ifdef MAZE_SOLVER_PRUNE_EN
            if (path_q[mv_idx]) path_q[cur_idx] <= 1'b0;
`endif
            // Goal takes precedence when it coincides with the move limit.
            if (mv_goal || step_d == STEP_W'(MAX_STEPS)) begin
              found_q <= mv_goal;
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign found_o      = found_q;
  assign pos_x_o      = pos_x_q;
  assign pos_y_o      = pos_y_q;
  assign step_count_o = step_q;
  assign path_data_o  = path_q;

endmodule

// File: tb/tb_maze_solver.sv
// Directed-vector bench for maze_solver: table of solves plus reset and ignored-start sequences.
module tb_maze_solver;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [255:0] maze_data_i = '0;
  logic [3:0]   start_x_i = '0, start_y_i = '0, goal_x_i = '0, goal_y_i = '0;
  logic         busy_o, done_o, found_o;
  logic [3:0]   pos_x_o, pos_y_o;
  logic [9:0]   step_count_o;
  logic [255:0] path_data_o;

  maze_solver dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .maze_data_i  (maze_data_i),
    .start_x_i    (start_x_i),
    .start_y_i    (start_y_i),
    .goal_x_i     (goal_x_i),
    .goal_y_i     (goal_y_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .found_o      (found_o),
    .pos_x_o      (pos_x_o),
    .pos_y_o      (pos_y_o),
    .step_count_o (step_count_o),
    .path_data_o  (path_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [255:0] maze;
    logic [3:0]   sx, sy, gx, gy;
    int           lat;
    logic         found;
    int           steps;
    logic [3:0]   ex, ey;
    logic [255:0] path;
  } vec_t;

  vec_t vecs[5];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"},  256'(busy_o), 256'(0));
    chk({tag, " done"},  256'(done_o), 256'(0));
    chk({tag, " found"}, 256'(found_o), 256'(0));
    chk({tag, " steps"}, 256'(step_count_o), 256'(0));
    chk({tag, " pos"},   256'({pos_x_o, pos_y_o}), 256'(0));
    chk({tag, " path"},  path_data_o, '0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    @(posedge clk); #1;
    maze_data_i = v.maze;
    start_x_i = v.sx; start_y_i = v.sy; goal_x_i = v.gx; goal_y_i = v.gy;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    maze_data_i = '0;
    chk({v.name, " busy after start"}, 256'(busy_o), 256'(v.lat != 0));
    lat = 0;
    while (!done_o && lat < 1100) begin
      @(posedge clk); #1;
      lat++;
      if (v.lat >= 8 && lat == 2) start_i = 1'b1;
      if (v.lat >= 8 && lat == 4) start_i = 1'b0;
    end
    start_i = 1'b0;
    chk({v.name, " done latency"}, 256'(lat), 256'(v.lat));
    chk({v.name, " found"}, 256'(found_o), 256'(v.found));
    chk({v.name, " steps"}, 256'(step_count_o), 256'(v.steps));
    chk({v.name, " pos"}, 256'({pos_x_o, pos_y_o}), 256'({v.ex, v.ey}));
    chk({v.name, " path"}, path_data_o, v.path);
    chk({v.name, " busy at done"}, 256'(busy_o), 256'(0));
    @(posedge clk); #1;
    chk({v.name, " done one cycle"}, 256'(done_o), 256'(0));
    chk({v.name, " found held"}, 256'(found_o), 256'(v.found));
    chk({v.name, " steps held"}, 256'(step_count_o), 256'(v.steps));
  endtask

  initial begin
    logic [255:0] m;
    logic [255:0] p;

    m = '0; m[5:0] = '1;
    p = '0; p[5:0] = '1;
    vecs[0] = '{"corridor", m, 4'd0, 4'd0, 4'd5, 4'd0, 5, 1'b1, 5, 4'd5, 4'd0, p};

    m = '0; m[3:0] = '1; m[16] = 1'b1;
`ifdef MAZE_SOLVER_PRUNE_EN
    p = '0; p[0] = 1'b1; p[16] = 1'b1;
`else
    p = m;
`endif
    vecs[1] = '{"turnaround", m, 4'd0, 4'd0, 4'd0, 4'd1, 7, 1'b1, 7, 4'd0, 4'd1, p};

    m = '0; m[5:0] = '1;
    vecs[2] = '{"start wall", m, 4'd2, 4'd2, 4'd5, 4'd0, 0, 1'b0, 0, 4'd2, 4'd2, '0};

    m = '0; m[119] = 1'b1; m[118] = 1'b1;
    p = '0; p[119] = 1'b1;
    vecs[3] = '{"start is goal", m, 4'd7, 4'd7, 4'd7, 4'd7, 0, 1'b1, 0, 4'd7, 4'd7, p};

    // Walker circles the closed 2x2 block; both builds end with all four cells marked.
    m = '0; m[0] = 1'b1; m[1] = 1'b1; m[16] = 1'b1; m[17] = 1'b1;
    vecs[4] = '{"closed block", m, 4'd0, 4'd0, 4'd5, 4'd5, 1023, 1'b0, 1023, 4'd0, 4'd1, m};

    #1;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Start held into the DONE cycle must not launch a second solve.
    @(posedge clk); #1;
    m = '0; m[119] = 1'b1;
    maze_data_i = m;
    start_x_i = 4'd7; start_y_i = 4'd7; goal_x_i = 4'd7; goal_y_i = 4'd7;
    start_i = 1'b1;
    @(posedge clk); #1;
    chk("done-hold done", 256'(done_o), 256'(1));
    maze_data_i = '0; start_x_i = 4'd0; start_y_i = 4'd0;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("done-hold done low", 256'(done_o), 256'(0));
    chk("done-hold found", 256'(found_o), 256'(1));
    chk("done-hold pos", 256'({pos_x_o, pos_y_o}), 256'(8'h77));

    // Reset in the middle of the corridor walk.
    @(posedge clk); #1;
    maze_data_i = vecs[0].maze;
    start_x_i = 4'd0; start_y_i = 4'd0; goal_x_i = 4'd5; goal_y_i = 4'd0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrun steps", 256'(step_count_o), 256'(3));
    chk("midrun pos", 256'({pos_x_o, pos_y_o}), 256'(8'h30));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrun reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
